// File: rtl/reg_file_wb.sv
// Architectural register file with writeback commit, two ALU read ports and
// one display/debug read port. Register 0 always reads as zero.
module reg_file_wb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   input  logic [ADDR_W-1:0] DbgReg,
   output logic [DATA_W-1:0] DbgData,
   output logic [15:0]       WrCount
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [NREG];
   logic              wr_en;

   // writes to index 0 are dropped entirely, so mem[0] stays at its reset value
   assign wr_en = RegWrite && (WriteReg != '0);

   // register array: async clear, commit on rising edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[WriteReg] <= WriteData;
      end
   end

   // committed-write counter, wraps naturally at 16 bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WrCount <= '0;
      end else if (wr_en) begin
         WrCount <= WrCount + 16'd1;
      end
   end

   // read port 1: forced to zero during reset, write-first forwarding when enabled
   always_comb begin
      ReadData1 = '0;
      if (!rst && (ReadReg1 != '0)) begin
         if ((BYPASS != 0) && wr_en && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
         end else begin
            ReadData1 = mem[ReadReg1];
         end
      end
   end

   // read port 2: same rules as port 1, forwarding decided independently
   always_comb begin
      ReadData2 = '0;
      if (!rst && (ReadReg2 != '0)) begin
         if ((BYPASS != 0) && wr_en && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
         end else begin
            ReadData2 = mem[ReadReg2];
         end
      end
   end

   // debug port shows only the stored value, never the in-flight write
   always_comb begin
      DbgData = '0;
      if (!rst && (DbgReg != '0)) begin
         DbgData = mem[DbgReg];
      end
   end

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomized bench for reg_file_wb against an array-based reference model.
module tb_reg_file_wb;

   logic        clk;
   logic        rst;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [4:0]  DbgReg;
   logic [31:0] DbgData;
   logic [15:0] WrCount;

   int tests_run;
   int tests_failed;

   logic [31:0] ref_mem [32];
   int          ref_cnt;

   reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2),
      .DbgReg    (DbgReg),
      .DbgData   (DbgData),
      .WrCount   (WrCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit fwd);
      logic [31:0] v;
      v = 32'h0;
      if (rst || idx == 5'd0) v = 32'h0;
      else if (fwd && RegWrite && WriteReg != 5'd0 && WriteReg == idx) v = WriteData;
      else v = ref_mem[idx];
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      ref_cnt = 0;
   endtask

   task automatic model_commit();
      if (!rst && RegWrite && WriteReg != 5'd0) begin
         ref_mem[WriteReg] = WriteData;
         ref_cnt = (ref_cnt + 1) % 65536;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_rd1"}, ReadData1, exp_read(ReadReg1, 1'b1));
      chk({tag, "_rd2"}, ReadData2, exp_read(ReadReg2, 1'b1));
      chk({tag, "_dbg"}, DbgData, exp_read(DbgReg, 1'b0));
      chk({tag, "_cnt"}, {16'h0, WrCount}, ref_cnt[31:0]);
   endtask

   // check at the falling edge, then commit through the rising edge
   task automatic step(input string tag);
      @(negedge clk);
      check_outputs(tag);
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic fast_write(input logic [4:0] idx, input logic [31:0] d);
      RegWrite = 1'b1; WriteReg = idx; WriteData = d;
      @(posedge clk);
      model_commit();
      #1;
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      model_clear();
      rst = 1'b1; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'h0;
      ReadReg1 = 5'd1; ReadReg2 = 5'd2; DbgReg = 5'd3;
      #12;
      check_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // write 0xDEADBEEF to reg 8
      RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF;
      ReadReg1 = 5'd1; ReadReg2 = 5'd2; DbgReg = 5'd8;
      step("wr8");
      RegWrite = 1'b0; ReadReg1 = 5'd8;
      @(negedge clk);
      chk("wr8_rd1", ReadData1, 32'hDEADBEEF);
      chk("wr8_cnt", {16'h0, WrCount}, 32'd1);

      // write to reg 0 is dropped
      RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678; ReadReg1 = 5'd0;
      step("wr0");
      RegWrite = 1'b0;
      @(negedge clk);
      chk("wr0_rd1", ReadData1, 32'h0);
      chk("wr0_cnt", {16'h0, WrCount}, 32'd1);
      @(posedge clk); #1;

      // forwarding: reg 9 holds 5, in-flight write of 7
      fast_write(5'd9, 32'd5);
      RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'd7;
      ReadReg1 = 5'd9; ReadReg2 = 5'd9; DbgReg = 5'd9;
      @(negedge clk);
      chk("byp_rd1", ReadData1, 32'd7);
      chk("byp_rd2", ReadData2, 32'd7);
      chk("byp_dbg", DbgData, 32'd5);
      @(posedge clk); model_commit(); #1;
      RegWrite = 1'b0;
      @(negedge clk);
      chk("byp_after_dbg", DbgData, 32'd7);
      @(posedge clk); #1;

      // randomized traffic, with frequent index collisions
      for (int n = 0; n < 400; n++) begin
         RegWrite  = ($urandom_range(0, 3) != 0);
         WriteReg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         WriteData = $urandom;
         ReadReg1  = ($urandom_range(0, 2) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         ReadReg2  = ($urandom_range(0, 2) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         DbgReg    = ($urandom_range(0, 2) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         step("rnd");
      end

      // asynchronous reset mid-run, observed before the next edge
      RegWrite = 1'b0;
      for (int i = 1; i < 4; i++) fast_write(5'(i + 10), 32'hA5A50000 + i);
      RegWrite = 1'b1; WriteReg = 5'd12; WriteData = 32'h55;
      ReadReg1 = 5'd11; ReadReg2 = 5'd12; DbgReg = 5'd13;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_rd1", ReadData1, 32'h0);
      chk("arst_rd2", ReadData2, 32'h0);
      chk("arst_dbg", DbgData, 32'h0);
      chk("arst_cnt", {16'h0, WrCount}, 32'h0);
      model_clear();

      // write presented on an edge while in reset is discarded
      WriteReg = 5'd3; WriteData = 32'hAA;
      @(posedge clk);
      model_commit();
      #1;
      rst = 1'b0; RegWrite = 1'b0; ReadReg1 = 5'd3; DbgReg = 5'd3;
      @(negedge clk);
      chk("rstwr_rd1", ReadData1, 32'h0);
      chk("rstwr_dbg", DbgData, 32'h0);
      check_outputs("rstwr");
      @(posedge clk); #1;

      // counter wrap after 65536 committed writes
      for (int n = 0; n < 65535; n++) fast_write(5'($urandom_range(1, 31)), $urandom);
      RegWrite = 1'b0;
      @(negedge clk);
      chk("cnt_ffff", {16'h0, WrCount}, 32'h0000FFFF);
      @(posedge clk); #1;
      fast_write(5'd20, 32'hCAFEF00D);
      RegWrite = 1'b0; ReadReg1 = 5'd20;
      @(negedge clk);
      chk("cnt_wrap", {16'h0, WrCount}, 32'h0);
      chk("cnt_wrap_rd1", ReadData1, 32'hCAFEF00D);
      check_outputs("final");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
